// File: rtl/ins_mem_loader_pkg.sv
// Shared processor package: loader state encoding and program-image field widths.
package ins_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_DAT_HI = 3'd4,
        ST_WRITE  = 3'd5,
        ST_START  = 3'd6,
        ST_ERROR  = 3'd7
    } loader_state_t;

    // Length and words each arrive as a full low byte plus a 4-bit high nibble.
    localparam int LEN_LO_BITS = 8;
    localparam int LEN_HI_BITS = 4;
    localparam int LEN_WIDTH   = LEN_LO_BITS + LEN_HI_BITS;
    localparam int WORD_WIDTH  = 12;

endpackage

// File: rtl/ins_mem_loader.sv
// Byte-stream program loader: receives a 12-bit length then little-endian
// 12-bit words, writes them into instruction memory and pulses start.
module ins_mem_loader
    import ins_mem_loader_pkg::*;
#(
    parameter int IR_width = 12,
    parameter int Im_width = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_en,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [Im_width-1:0] im_address,
    output logic [IR_width-1:0] im_data,
    output logic                im_wren,
    output logic                start,
    output logic                busy,
    output logic                done,
    output logic                err
);

    // Compare width must hold both the 12-bit length and the 2^Im_width word count.
    localparam int CW = (Im_width + 1 > LEN_WIDTH) ? Im_width + 1 : LEN_WIDTH;
    localparam logic [CW-1:0] MAX_LEN = CW'(1) << Im_width;

    loader_state_t         state_reg, state_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;
    logic [7:0]            lo_reg, lo_next;
    logic [WORD_WIDTH-1:0] word_reg, word_next;
    logic [Im_width-1:0]   index_reg, index_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;

    logic                  accept;
    logic [LEN_WIDTH-1:0]  len_rx;
    logic [CW-1:0]         index_plus;

    assign accept     = rx_valid && rx_ready;
    assign len_rx     = {rx_data[LEN_HI_BITS-1:0], len_reg[LEN_LO_BITS-1:0]};
    assign index_plus = CW'(index_reg) + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            lo_reg    <= '0;
            word_reg  <= '0;
            index_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            lo_reg    <= lo_next;
            word_reg  <= word_next;
            index_reg <= index_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        lo_next    = lo_reg;
        word_next  = word_reg;
        index_next = index_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_en) begin
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                    index_next = '0;
                    state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_next   = {{LEN_HI_BITS{1'b0}}, rx_data};
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_next = len_rx;
                    if (len_rx == '0)
                        state_next = ST_START;
                    else if (CW'(len_rx) > MAX_LEN)
                        state_next = ST_ERROR;
                    else
                        state_next = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (accept) begin
                    lo_next    = rx_data;
                    state_next = ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                if (accept) begin
                    word_next  = {rx_data[3:0], lo_reg};
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                index_next = index_reg + Im_width'(1);
                state_next = (index_plus == CW'(len_reg)) ? ST_START : ST_DAT_LO;
            end
            ST_START: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERROR: begin
                err_next   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registers so address/data stay steady through WRITE.
    assign rx_ready   = (state_reg == ST_LEN_LO) || (state_reg == ST_LEN_HI) ||
                        (state_reg == ST_DAT_LO) || (state_reg == ST_DAT_HI);
    assign im_wren    = (state_reg == ST_WRITE);
    assign im_address = index_reg;
    assign im_data    = IR_width'(word_reg);
    assign start      = (state_reg == ST_START);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: random byte streams against a
// program-image reference model.
module tb_ins_mem_loader;

    localparam int IRW = 12;
    localparam int IMW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_en;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [IMW-1:0] im_address;
    logic [IRW-1:0] im_data;
    logic           im_wren;
    logic           start;
    logic           busy;
    logic           done;
    logic           err;

    always #5 clk = ~clk;

    ins_mem_loader #(.IR_width(IRW), .Im_width(IMW)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .im_address(im_address),
        .im_data(im_data), .im_wren(im_wren), .start(start), .busy(busy),
        .done(done), .err(err)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [7:0] bq[$];
    int obs_addr[$];
    int obs_data[$];
    int obs_starts;
    int exp_addr[$];
    int exp_data[$];
    int exp_starts;
    bit exp_done;
    bit exp_err;

    always @(negedge clk) begin
        if (!reset) begin
            if (im_wren) begin
                obs_addr.push_back(int'(im_address));
                obs_data.push_back(int'(im_data));
            end
            if (start) obs_starts++;
        end
    end

    // Reference: what a program image of bytes bq should leave behind.
    task automatic model_load();
        int n;
        n = int'(bq[0]) + 256 * int'(bq[1][3:0]);
        exp_addr.delete();
        exp_data.delete();
        if (n > 256) begin
            exp_err = 1; exp_done = 0; exp_starts = 0;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i % 256);
                exp_data.push_back(int'(bq[2 + 2 * i]) + 256 * int'(bq[3 + 2 * i][3:0]));
            end
            exp_err = 0; exp_done = 1; exp_starts = 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        int t;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        @(negedge clk);
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            chk_cnt++;
            $display("FAIL send_byte_timeout: rx_ready=%0b required 1", rx_ready);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic pulse_load_en();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic run_load(input int gap_max, input bit poke);
        int t;
        obs_addr.delete();
        obs_data.delete();
        obs_starts = 0;
        pulse_load_en();
        foreach (bq[i]) begin
            send_byte(bq[i], gap_max);
            if (poke && i == 3) pulse_load_en();
        end
        t = 0;
        @(negedge clk);
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            chk_cnt++;
            $display("FAIL load_idle_timeout: busy=%0b required 0", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        chk_cnt++;
        if ({rx_ready, im_wren, start, busy, done, err} !== 6'b0)
            $display("FAIL reset_flags: got %b required 000000",
                     {rx_ready, im_wren, start, busy, done, err});
        else pass_cnt++;
        chk_cnt++;
        if (im_address !== '0 || im_data !== '0)
            $display("FAIL reset_bus: addr=%h data=%h required 0/0", im_address, im_data);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b required 0", busy);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_directed();
        logic [7:0] v0[8] = '{8'h03, 8'h00, 8'h23, 8'h01, 8'hBC, 8'h0A, 8'h05, 8'h00};
        logic [7:0] v1[6] = '{8'h02, 8'h00, 8'h34, 8'hF7, 8'hAA, 8'h5B};
        int ref0[3] = '{'h123, 'hABC, 'h005};
        for (int k = 0; k < 2; k++) begin
            bq.delete();
            if (k == 0) foreach (v0[i]) bq.push_back(v0[i]);
            else        foreach (v1[i]) bq.push_back(v1[i]);
            model_load();
            run_load(k, k == 1);
            chk_cnt++;
            if (obs_addr.size() != exp_addr.size())
                $display("FAIL dir%0d_nwrites: got %0d required %0d", k, obs_addr.size(), exp_addr.size());
            else pass_cnt++;
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                chk_cnt++;
                if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i])
                    $display("FAIL dir%0d_write%0d: got %h@%0d required %h@%0d", k, i,
                             obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
                else pass_cnt++;
            end
            chk_cnt++;
            if (obs_starts != exp_starts || done !== exp_done || err !== exp_err)
                $display("FAIL dir%0d_status: starts=%0d done=%b err=%b required %0d %b %b", k,
                         obs_starts, done, err, exp_starts, exp_done, exp_err);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_data.size() < 1 || obs_data[0] != 'h734)
            $display("FAIL garbage_nibble: got %h required 734", obs_data.size() ? obs_data[0] : -1);
        else pass_cnt++;
        $display("test_directed done (first word ref %h)", ref0[0]);
    endtask

    task automatic test_len_timing();
        // N = 0: start pulses the cycle right after LEN_HI.
        obs_addr.delete(); obs_data.delete(); obs_starts = 0;
        pulse_load_en();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk_cnt++;
        if (start !== 1'b1) $display("FAIL zero_len_start: got %b required 1", start);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if ({start, done, busy} !== 3'b010)
            $display("FAIL zero_len_after: start/done/busy=%b required 010", {start, done, busy});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (obs_addr.size() != 0 || obs_starts != 1)
            $display("FAIL zero_len_count: writes=%0d starts=%0d required 0/1", obs_addr.size(), obs_starts);
        else pass_cnt++;
        // N = 257: rejected, idle two cycles after the length completes.
        obs_addr.delete(); obs_data.delete(); obs_starts = 0;
        pulse_load_en();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk_cnt++;
        if ({busy, err, start, im_wren, done} !== 5'b10000)
            $display("FAIL too_long_error: busy/err/start/wren/done=%b required 10000",
                     {busy, err, start, im_wren, done});
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if ({busy, err, done} !== 3'b010)
            $display("FAIL too_long_after: busy/err/done=%b required 010", {busy, err, done});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (obs_addr.size() != 0 || obs_starts != 0)
            $display("FAIL too_long_count: writes=%0d starts=%0d required 0/0", obs_addr.size(), obs_starts);
        else pass_cnt++;
        $display("test_len_timing done");
    endtask

    task automatic test_full();
        bq.delete();
        bq.push_back(8'h00);
        bq.push_back(8'h01);
        repeat (512) bq.push_back(8'($urandom));
        model_load();
        run_load(3, 1'b0);
        chk_cnt++;
        if (obs_addr.size() != 256)
            $display("FAIL full_nwrites: got %0d required 256", obs_addr.size());
        else pass_cnt++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            chk_cnt++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i])
                $display("FAIL full_write%0d: got %h@%0d required %h@%0d", i,
                         obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_starts != 1 || done !== 1'b1 || im_address !== '0)
            $display("FAIL full_status: starts=%0d done=%b index=%0d required 1 1 0",
                     obs_starts, done, im_address);
        else pass_cnt++;
        $display("test_full done");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] w[8];
        foreach (w[i]) w[i] = 8'($urandom);
        obs_addr.delete(); obs_data.delete(); obs_starts = 0;
        pulse_load_en();
        send_byte(8'h04, 1);
        send_byte(8'h00, 1);
        for (int i = 0; i < 4; i++) send_byte(w[i], 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_cnt++;
        if ({rx_ready, im_wren, start, busy, done, err} !== 6'b0 || im_address !== '0 || im_data !== '0)
            $display("FAIL mid_reset_outputs: flags=%b addr=%h data=%h required all 0",
                     {rx_ready, im_wren, start, busy, done, err}, im_address, im_data);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 4; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = w[i];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (obs_addr.size() != 2 || obs_starts != 0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mid_reset_aborted: writes=%0d starts=%0d busy=%b done=%b required 2 0 0 0",
                     obs_addr.size(), obs_starts, busy, done);
        else pass_cnt++;
        chk_cnt++;
        if (obs_data.size() != 2 ||
            obs_data[1] != int'(w[2]) + 256 * int'(w[3][3:0]) || obs_addr[1] != 1)
            $display("FAIL mid_reset_word1: got %h@%0d required %h@1",
                     obs_data.size() > 1 ? obs_data[1] : -1, obs_addr.size() > 1 ? obs_addr[1] : -1,
                     int'(w[2]) + 256 * int'(w[3][3:0]));
        else pass_cnt++;
        bq.delete();
        bq.push_back(8'h05);
        bq.push_back(8'h00);
        repeat (10) bq.push_back(8'($urandom));
        model_load();
        run_load(2, 1'b0);
        chk_cnt++;
        if (obs_addr.size() != exp_addr.size() || obs_starts != 1 || done !== 1'b1)
            $display("FAIL post_reset_load: writes=%0d starts=%0d done=%b required %0d 1 1",
                     obs_addr.size(), obs_starts, done, exp_addr.size());
        else pass_cnt++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            chk_cnt++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i])
                $display("FAIL post_reset_write%0d: got %h@%0d required %h@%0d", i,
                         obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
            else pass_cnt++;
        end
        $display("test_reset_mid_load done");
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 8; k++) begin
            n = (k == 0) ? 256 + int'($urandom_range(44, 1)) : int'($urandom_range(300, 0));
            bq.delete();
            bq.push_back(8'(n));
            bq.push_back({4'($urandom), 4'(n >> 8)});
            if (n <= 256) repeat (2 * n) bq.push_back(8'($urandom));
            model_load();
            run_load(2, (n > 1) && $urandom_range(1, 0) == 1);
            chk_cnt++;
            if (obs_addr.size() != exp_addr.size())
                $display("FAIL rand%0d_nwrites: n=%0d got %0d required %0d", k, n,
                         obs_addr.size(), exp_addr.size());
            else pass_cnt++;
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                chk_cnt++;
                if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i])
                    $display("FAIL rand%0d_write%0d: got %h@%0d required %h@%0d", k, i,
                             obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
                else pass_cnt++;
            end
            chk_cnt++;
            if (obs_starts != exp_starts || done !== exp_done || err !== exp_err)
                $display("FAIL rand%0d_status: n=%0d starts=%0d done=%b err=%b required %0d %b %b",
                         k, n, obs_starts, done, err, exp_starts, exp_done, exp_err);
            else pass_cnt++;
            $display("load n=%0d writes=%0d starts=%0d err=%b", n, obs_addr.size(), obs_starts, err);
        end
    endtask

    initial begin
        reset    = 1'b1;
        load_en  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        obs_starts = 0;
        test_reset();
        test_directed();
        test_len_timing();
        test_full();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ins_mem_loader.md
INS_MEM_LOADER -- requirements
Module: ins_mem_loader

Interface
REQ-001 SHALL have parameter IR_width, default 12, instruction word width.
REQ-002 SHALL have parameter Im_width, default 8, instruction memory address width (2^Im_width words).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_en  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port rx_data  input  8  incoming program byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port im_address  output  Im_width  instruction memory write address.
REQ-010 SHALL have port im_data  output  IR_width  instruction memory write data.
REQ-011 SHALL have port im_wren  output  1  instruction memory write enable.
REQ-012 SHALL have port start  output  1  one-cycle processor start pulse after a successful load.
REQ-013 SHALL have port busy  output  1  a load is in progress.
REQ-014 SHALL have port done  output  1  sticky; last load completed successfully.
REQ-015 SHALL have port err  output  1  sticky; last load rejected (length too large).

Function
REQ-016 SHALL accept a byte only in a cycle where rx_valid and rx_ready are both high; rx_data ignored otherwise.
REQ-017 SHALL implement states IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, START, ERROR.
REQ-018 SHALL drive rx_ready high only in LEN_LO, LEN_HI, DAT_LO, DAT_HI.
REQ-019 SHALL, in IDLE on load_en, clear done and err, zero the word index, and enter LEN_LO; load_en in any other state is ignored.
REQ-020 SHALL take length N as 12 bits: LEN_LO byte = N[7:0], LEN_HI byte bits[3:0] = N[11:8], bits[7:4] discarded.
REQ-021 SHALL, after LEN_HI: N = 0 -> START; N > 2^Im_width -> ERROR; else -> DAT_LO.
REQ-022 SHALL assemble each word little-endian: DAT_LO byte = word[7:0], DAT_HI byte bits[3:0] = word[11:8], bits[7:4] discarded.
REQ-023 SHALL, after DAT_HI acceptance, enter WRITE for exactly one cycle with im_wren = 1, im_address = word index, im_data = assembled word.
REQ-024 SHALL, leaving WRITE, increment the word index (mod 2^Im_width) and go to START if index+1 = N, else DAT_LO.
REQ-025 SHALL hold im_wren low in every state except WRITE; im_address/im_data are don't-care when im_wren is low but SHALL not glitch during WRITE.
REQ-026 SHALL, in START, pulse start high for one cycle, set done, then return to IDLE.
REQ-027 SHALL, in ERROR, set err, perform no writes and no start, and return to IDLE next cycle.
REQ-028 SHALL drive busy high in every state except IDLE.
REQ-029 SHALL tolerate arbitrary rx_valid gaps; a byte is never lost or duplicated while stalled.

Reset
REQ-030 SHALL on reset (any time, including mid-load) immediately force state IDLE, word index 0, and rx_ready, im_wren, start, busy, done, err, im_address, im_data all 0.
REQ-031 SHALL not write memory or pulse start due to a load aborted by reset.

Structure
REQ-032 SHALL place the state encoding and the length-field widths in the shared processor package.
REQ-033 SHALL be a single module; byte-to-word assembly inline, no sub-module.

Verification
REQ-034 Load N=3, words 0x123, 0xABC, 0x005 (bytes 03 00 23 01 BC 0A 05 00) -> writes addr 0/1/2 with those data, one start pulse, done=1.
REQ-035 N=0 (bytes 00 00) -> no im_wren, start pulse one cycle after LEN_HI, done=1.
REQ-036 N=257 (bytes 01 01) -> err=1, no writes, no start, busy low two cycles later.
REQ-037 N=256 full load with random rx_valid gaps -> exactly 256 writes, addr 0..255 in order, final index wraps to 0, start once.
REQ-038 Reset asserted after second data word of N=4 -> all outputs 0 same cycle, no further writes, no start; new load_en then works.
REQ-039 High nibble garbage (DAT_HI byte 0xF7) -> stored word bits[11:8] = 0x7; load_en asserted mid-load ignored.
